// File: rtl/pipelined_equiv_checker.sv
// Sweeps every input vector into a reference and a candidate module, lines their outputs up
// by the pipeline depth, and keeps mismatch statistics plus the first failing vector.
module pipelined_equiv_checker #(
  parameter int IN_WIDTH          = 2,
  parameter int OUT_WIDTH         = 1,
  parameter int PIPELINE_DEPTH    = 2,
  parameter int ABORT_ON_MISMATCH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic [IN_WIDTH-1:0]  stim_o,
  output logic                 stim_valid_o,
  input  logic [OUT_WIDTH-1:0] gt_out_i,
  input  logic [OUT_WIDTH-1:0] dut_out_i,
  output logic                 mismatch_o,
  output logic [IN_WIDTH:0]    fail_count_o,
  output logic [IN_WIDTH:0]    check_count_o,
  output logic [IN_WIDTH-1:0]  first_fail_in_o,
  output logic [OUT_WIDTH-1:0] first_fail_gt_o,
  output logic [OUT_WIDTH-1:0] first_fail_dut_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  localparam logic [IN_WIDTH-1:0] LAST = '1;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   stim_q, stim_d;
  logic [IN_WIDTH:0]     fc_q, fc_d;
  logic [IN_WIDTH:0]     cc_q, cc_d;
  logic [IN_WIDTH-1:0]   ffi_q, ffi_d;
  logic [OUT_WIDTH-1:0]  ffg_q, ffg_d;
  logic [OUT_WIDTH-1:0]  ffd_q, ffd_d;

  logic                  launch;
  logic                  stim_valid;
  logic                  busy;
  logic                  cmp_valid;
  logic [IN_WIDTH-1:0]   cmp_stim;
  logic                  cmp_fire;
  logic                  neq;
  logic                  mismatch;

  assign launch     = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign stim_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  // Case inequality so an X/Z on either side counts as a failure.
  assign neq        = (gt_out_i !== dut_out_i);
  assign cmp_fire   = busy && cmp_valid;
  assign mismatch   = cmp_fire && neq;

  // Delay line carrying {valid, stim} so each compare knows which vector it belongs to.
  generate
    if (PIPELINE_DEPTH == 0) begin : g_comb
      assign cmp_valid = stim_valid;
      assign cmp_stim  = stim_q;
    end else begin : g_pipe
      logic [PIPELINE_DEPTH-1:0] dv_q;
      logic [IN_WIDTH-1:0]       ds_q [PIPELINE_DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dv_q <= '0;
          for (int i = 0; i < PIPELINE_DEPTH; i++) ds_q[i] <= '0;
        end else if (launch) begin
          dv_q <= '0;
          for (int i = 0; i < PIPELINE_DEPTH; i++) ds_q[i] <= '0;
        end else begin
          dv_q[0] <= stim_valid;
          ds_q[0] <= stim_q;
          for (int i = 1; i < PIPELINE_DEPTH; i++) begin
            dv_q[i] <= dv_q[i-1];
            ds_q[i] <= ds_q[i-1];
          end
        end
      end

      assign cmp_valid = dv_q[PIPELINE_DEPTH-1];
      assign cmp_stim  = ds_q[PIPELINE_DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      fc_q    <= '0;
      cc_q    <= '0;
      ffi_q   <= '0;
      ffg_q   <= '0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      fc_q    <= fc_d;
      cc_q    <= cc_d;
      ffi_q   <= ffi_d;
      ffg_q   <= ffg_d;
      ffd_q   <= ffd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (mismatch && ABORT_ON_MISMATCH != 0) state_d = S_FAIL;
        else if (stim_q == LAST) state_d = (PIPELINE_DEPTH == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (mismatch && ABORT_ON_MISMATCH != 0) state_d = S_FAIL;
        else if (cmp_fire && cmp_stim == LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Compares only happen while busy, so an aborted sweep freezes its counts.
  always_comb begin
    stim_d = stim_q;
    fc_d   = fc_q;
    cc_d   = cc_q;
    ffi_d  = ffi_q;
    ffg_d  = ffg_q;
    ffd_d  = ffd_q;
    if (launch) begin
      stim_d = '0;
      fc_d   = '0;
      cc_d   = '0;
      ffi_d  = '0;
      ffg_d  = '0;
      ffd_d  = '0;
    end else begin
      if (state_q == S_RUN && stim_q != LAST) stim_d = stim_q + 1'b1;
      if (cmp_fire) begin
        cc_d = cc_q + 1'b1;
        if (neq) begin
          fc_d = fc_q + 1'b1;
          if (fc_q == '0) begin
            ffi_d = cmp_stim;
            ffg_d = gt_out_i;
            ffd_d = dut_out_i;
          end
        end
      end
    end
  end

  always_comb begin
    stim_o           = stim_q;
    stim_valid_o     = stim_valid;
    mismatch_o       = mismatch;
    fail_count_o     = fc_q;
    check_count_o    = cc_q;
    first_fail_in_o  = ffi_q;
    first_fail_gt_o  = ffg_q;
    first_fail_dut_o = ffd_q;
    busy_o           = busy;
    done_o           = (state_q == S_DONE) || (state_q == S_FAIL);
    pass_o           = done_o && (fc_q == '0);
    state_o          = state_q;
  end

endmodule

// File: tb/tb_pipelined_equiv_checker.sv
// Bench for pipelined_equiv_checker: three instances (depth 2 abort, depth 2 no-abort,
// depth 0) fed by small reference/candidate models, checked against an issued-vector scoreboard.
module tb_pipelined_equiv_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       start_a, start_b, start_c;
  logic [1:0] stim_a, stim_b, stim_c;
  logic       sv_a, sv_b, sv_c;
  logic       gt_a, gt_b, gt_c, dut_a, dut_b, dut_c;
  logic       mm_a, mm_b, mm_c;
  logic [2:0] fc_a, fc_b, fc_c, cc_a, cc_b, cc_c;
  logic [1:0] ffi_a, ffi_b, ffi_c;
  logic       ffg_a, ffg_b, ffg_c, ffd_a, ffd_b, ffd_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [2:0] st_a, st_b, st_c;

  int mode_a, mode_b;
  logic g1_a, g2_a, d1_a, d2_a, g1_b, g2_b, d1_b, d2_b;

  // mode 0: a&b two stages; 1: ~a|~b two stages; 2: a&b single stage
  always @(posedge clk) begin
    g1_a <= stim_a[1] & stim_a[0];
    g2_a <= g1_a;
    d1_a <= (mode_a == 1) ? (~stim_a[1] | ~stim_a[0]) : (stim_a[1] & stim_a[0]);
    d2_a <= d1_a;
    g1_b <= stim_b[1] & stim_b[0];
    g2_b <= g1_b;
    d1_b <= (mode_b == 1) ? (~stim_b[1] | ~stim_b[0]) : (stim_b[1] & stim_b[0]);
    d2_b <= d1_b;
  end
  assign gt_a  = g2_a;
  assign dut_a = (mode_a == 2) ? d1_a : d2_a;
  assign gt_b  = g2_b;
  assign dut_b = (mode_b == 2) ? d1_b : d2_b;
  assign gt_c  = stim_c[1] ^ stim_c[0];
  assign dut_c = stim_c[1] ^ stim_c[0];

  pipelined_equiv_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(2), .ABORT_ON_MISMATCH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .stim_o(stim_a), .stim_valid_o(sv_a),
    .gt_out_i(gt_a), .dut_out_i(dut_a), .mismatch_o(mm_a), .fail_count_o(fc_a),
    .check_count_o(cc_a), .first_fail_in_o(ffi_a), .first_fail_gt_o(ffg_a),
    .first_fail_dut_o(ffd_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .state_o(st_a));

  pipelined_equiv_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(2), .ABORT_ON_MISMATCH(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .stim_o(stim_b), .stim_valid_o(sv_b),
    .gt_out_i(gt_b), .dut_out_i(dut_b), .mismatch_o(mm_b), .fail_count_o(fc_b),
    .check_count_o(cc_b), .first_fail_in_o(ffi_b), .first_fail_gt_o(ffg_b),
    .first_fail_dut_o(ffd_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .state_o(st_b));

  pipelined_equiv_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(0), .ABORT_ON_MISMATCH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .stim_o(stim_c), .stim_valid_o(sv_c),
    .gt_out_i(gt_c), .dut_out_i(dut_c), .mismatch_o(mm_c), .fail_count_o(fc_c),
    .check_count_o(cc_c), .first_fail_in_o(ffi_c), .first_fail_gt_o(ffg_c),
    .first_fail_dut_o(ffd_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .state_o(st_c));

  int         sel;
  logic [1:0] s_stim, s_ffi;
  logic       s_sv, s_mm, s_ffg, s_ffd, s_busy, s_done, s_pass;
  logic [2:0] s_fc, s_cc, s_st;
  logic [19:0] s_all;

  always_comb begin
    {s_stim, s_sv, s_mm, s_fc, s_cc, s_ffi, s_ffg, s_ffd, s_busy, s_done, s_pass, s_st} = '0;
    case (sel)
      0: {s_stim, s_sv, s_mm, s_fc, s_cc, s_ffi, s_ffg, s_ffd, s_busy, s_done, s_pass, s_st} =
         {stim_a, sv_a, mm_a, fc_a, cc_a, ffi_a, ffg_a, ffd_a, busy_a, done_a, pass_a, st_a};
      1: {s_stim, s_sv, s_mm, s_fc, s_cc, s_ffi, s_ffg, s_ffd, s_busy, s_done, s_pass, s_st} =
         {stim_b, sv_b, mm_b, fc_b, cc_b, ffi_b, ffg_b, ffd_b, busy_b, done_b, pass_b, st_b};
      default: {s_stim, s_sv, s_mm, s_fc, s_cc, s_ffi, s_ffg, s_ffd, s_busy, s_done, s_pass, s_st} =
         {stim_c, sv_c, mm_c, fc_c, cc_c, ffi_c, ffg_c, ffd_c, busy_c, done_c, pass_c, st_c};
    endcase
    s_all = {s_stim, s_sv, s_mm, s_fc, s_cc, s_ffi, s_ffg, s_ffd, s_busy, s_done, s_pass, s_st};
  end

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  int         pulses, busy_cyc, timed_out;
  logic [2:0] first_cc;
  logic [1:0] e, g;

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Pulses start, then records issued vectors, mismatch pulses and busy cycles until done.
  task automatic drive_sweep(input int inst, input int extra);
    int finished;
    finished  = 0;
    got_q.delete();
    pulses    = 0;
    busy_cyc  = 0;
    timed_out = 0;
    first_cc  = '1;
    sel       = inst;
    @(posedge clk); #1 set_start(inst, 1'b1);
    @(posedge clk); #1 set_start(inst, 1'b0);
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (cyc == 0) first_cc = s_cc;
      if (s_sv) got_q.push_back(s_stim);
      if (s_busy) busy_cyc++;
      if (s_mm) pulses++;
      set_start(inst, (cyc == extra));
      if (s_done) begin
        set_start(inst, 1'b0);
        finished = 1;
        break;
      end
    end
    if (finished == 0) timed_out = 1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      checks++;
      if (s_all !== 20'd0) begin errors++; $display("FAIL reset_in_reset inst=%0d got=%h exp=0", i, s_all); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      checks++;
      if (s_all !== 20'd0) begin errors++; $display("FAIL reset_released inst=%0d got=%h exp=0", i, s_all); end
    end
  endtask

  task automatic test_match;
    mode_a = 0;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(0, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t1_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t1_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t1_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL t1_extra_stim got=%0d exp=0", got_q.size()); end
    checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL t1_pass got=%0d exp=1", s_pass); end
    checks++; if (s_fc !== 3'd0) begin errors++; $display("FAIL t1_fail_count got=%0d exp=0", s_fc); end
    checks++; if (s_cc !== 3'd4) begin errors++; $display("FAIL t1_check_count got=%0d exp=4", s_cc); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL t1_mismatch_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_abort;
    mode_a = 1;
    for (int v = 0; v < 3; v++) exp_q.push_back(2'(v));
    drive_sweep(0, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t2_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t2_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t2_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL t2_extra_stim got=%0d exp=0", got_q.size()); end
    checks++; if (s_ffi !== 2'd0) begin errors++; $display("FAIL t2_first_in got=%0d exp=0", s_ffi); end
    checks++; if (s_ffg !== 1'b0) begin errors++; $display("FAIL t2_first_gt got=%0d exp=0", s_ffg); end
    checks++; if (s_ffd !== 1'b1) begin errors++; $display("FAIL t2_first_dut got=%0d exp=1", s_ffd); end
    checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL t2_pass got=%0d exp=0", s_pass); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL t2_mismatch_pulses got=%0d exp=1", pulses); end
    repeat (3) @(negedge clk);
    checks++; if (s_fc !== 3'd1) begin errors++; $display("FAIL t2_fail_count got=%0d exp=1", s_fc); end
    checks++; if (s_cc !== 3'd1) begin errors++; $display("FAIL t2_check_count got=%0d exp=1", s_cc); end
    checks++; if (s_done !== 1'b1 || s_busy !== 1'b0 || s_sv !== 1'b0) begin
      errors++; $display("FAIL t2_frozen got=done%0d busy%0d sv%0d exp=done1 busy0 sv0", s_done, s_busy, s_sv);
    end
  endtask

  task automatic test_no_abort;
    mode_b = 1;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(1, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t3_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t3_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t3_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (s_fc !== 3'd4) begin errors++; $display("FAIL t3_fail_count got=%0d exp=4", s_fc); end
    checks++; if (s_cc !== 3'd4) begin errors++; $display("FAIL t3_check_count got=%0d exp=4", s_cc); end
    checks++; if (s_ffi !== 2'd0) begin errors++; $display("FAIL t3_first_in got=%0d exp=0", s_ffi); end
    checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL t3_pass got=%0d exp=0", s_pass); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL t3_mismatch_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_misaligned;
    mode_a = 2;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(0, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t4_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t4_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t4_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (s_ffi !== 2'd2) begin errors++; $display("FAIL t4_first_in got=%0d exp=2", s_ffi); end
    checks++; if (s_ffg !== 1'b0 || s_ffd !== 1'b1) begin errors++; $display("FAIL t4_first_vals got=gt%0d dut%0d exp=gt0 dut1", s_ffg, s_ffd); end
    checks++; if (s_cc !== 3'd3) begin errors++; $display("FAIL t4_check_count got=%0d exp=3", s_cc); end
    checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL t4_pass got=%0d exp=0", s_pass); end
  endtask

  task automatic test_reset_mid_run;
    mode_a = 0;
    sel = 0;
    got_q.delete();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      if (s_sv) got_q.push_back(s_stim);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t5_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t5_stim got=%0d exp=%0d", g, e); end end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_all !== 20'd0) begin errors++; $display("FAIL t5_async_clear got=%h exp=0", s_all); end
    @(negedge clk); rst_n = 1'b1;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(0, -1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t5_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t5_rerun_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t5_rerun_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL t5_pass got=%0d exp=1", s_pass); end
    checks++; if (s_cc !== 3'd4 || s_fc !== 3'd0) begin errors++; $display("FAIL t5_counts got=cc%0d fc%0d exp=cc4 fc0", s_cc, s_fc); end
  endtask

  task automatic test_comb_depth0;
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(2, 1);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL t6_timeout got=%0d exp=0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t6_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t6_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL t6_extra_stim got=%0d exp=0", got_q.size()); end
    checks++; if (busy_cyc != 4) begin errors++; $display("FAIL t6_run_cycles got=%0d exp=4", busy_cyc); end
    checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL t6_pass got=%0d exp=1", s_pass); end
    checks++; if (s_cc !== 3'd4) begin errors++; $display("FAIL t6_check_count got=%0d exp=4", s_cc); end
    for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
    drive_sweep(2, -1);
    checks++; if (first_cc !== 3'd0) begin errors++; $display("FAIL t6_rerun_cleared got=%0d exp=0", first_cc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL t6_rerun_stim missing exp=%0d", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL t6_rerun_stim got=%0d exp=%0d", g, e); end end
    end
    checks++; if (s_cc !== 3'd4 || s_pass !== 1'b1) begin errors++; $display("FAIL t6_rerun_result got=cc%0d pass%0d exp=cc4 pass1", s_cc, s_pass); end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    mode_a  = 0;
    mode_b  = 0;
    sel     = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_match();
    test_abort();
    test_no_abort();
    test_misaligned();
    test_reset_mid_run();
    test_comb_depth0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
